// File: rtl/ly_2257_pkg.sv
// ly_2257_pkg: shared widths, FSM states and light-bar pattern encoder
package ly_2257_pkg;

    localparam int CODE_W = 7;
    localparam int LVL_W  = 3;
    localparam int CNT_W  = 4;
    localparam int N_LVL  = 7;

    typedef enum logic {STABLE, SETTLING} state_t;

    typedef struct packed {
        logic             ok;
        logic [LVL_W-1:0] lvl;
    } enc_t;

    localparam logic [CODE_W-1:0] LEGAL [N_LVL] = '{
        7'b0000000, 7'b0000001, 7'b0000011, 7'b0000111,
        7'b0001111, 7'b0011111, 7'b0111111
    };

    function automatic enc_t encode(input logic [CODE_W-1:0] c);
        enc_t r;
        r.ok  = 1'b0;
        r.lvl = '0;
        for (int i = 0; i < N_LVL; i++)
            if (c == LEGAL[i]) begin
                r.ok  = 1'b1;
                r.lvl = LVL_W'(i);
            end
        return r;
    endfunction

endpackage

// File: rtl/ly_2257_sync2.sv
// ly_2257_sync2: parameterized-width two-flop synchronizer
module ly_2257_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end

endmodule

// File: rtl/ly_2257_2_enc.sv
// ly_2257_2_enc: debounced light-bar to level encoder with update pulse and illegal flag
module ly_2257_2_enc
    import ly_2257_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] codein,
    output logic [LVL_W-1:0]  Q,
    output logic              upd,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CODE_W-1:0] s2, cand;
    logic [CNT_W-1:0]  cnt;
    state_t            state;
    enc_t              e;

    ly_2257_sync2 #(.W(CODE_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (codein),
        .q   (s2)
    );

    assign e = encode(cand);

    // any change of s2 restarts the settle, whatever the current state
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cand  <= '0;
            cnt   <= '0;
            state <= STABLE;
            Q     <= '0;
            upd   <= 1'b0;
            err   <= 1'b0;
        end else begin
            upd <= 1'b0;
            if (s2 != cand) begin
                cand  <= s2;
                cnt   <= '0;
                state <= SETTLING;
            end else if (state == SETTLING) begin
                if (cnt == LAST) begin
                    state <= STABLE;
                    err   <= !e.ok;
                    if (e.ok) begin
                        Q   <= e.lvl;
                        upd <= e.lvl != Q;
                    end
                end else
                    cnt <= cnt + 1'b1;
            end
        end

endmodule

// File: tb/tb_ly_2257_2_enc.sv
// tb_ly_2257_2_enc: scoreboard bench for default and STABLE_CYCLES=1 builds
module tb_ly_2257_2_enc;

    typedef struct {
        int         cyc;
        int         dut;
        logic [4:0] v;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [6:0]      c4 = '0, c1 = '0;
    logic [1:0][2:0] oq;
    logic [1:0]      oupd, oerr;
    logic [1:0]      hit;
    int              ncyc = 0;
    int              checks = 0;
    int              errors = 0;
    exp_t            sb[$];

    ly_2257_2_enc #(.STABLE_CYCLES(4)) d4 (
        .clk(clk), .rst(rst), .codein(c4), .Q(oq[0]), .upd(oupd[0]), .err(oerr[0])
    );

    ly_2257_2_enc #(.STABLE_CYCLES(1)) d1 (
        .clk(clk), .rst(rst), .codein(c1), .Q(oq[1]), .upd(oupd[1]), .err(oerr[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // accepts land at the negedge sample N+3 posedges after the drive point
    always @(negedge clk) begin
        hit = '0;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].cyc == ncyc) begin
                hit[sb[i].dut] = 1'b1;
                chk(sb[i].dut == 0 ? "accept_n4" : "accept_n1",
                    {oq[sb[i].dut], oupd[sb[i].dut], oerr[sb[i].dut]}, sb[i].v);
                sb.delete(i);
            end
        for (int d = 0; d < 2; d++)
            if (!rst && !hit[d])
                chk(d == 0 ? "upd_idle_n4" : "upd_idle_n1", {4'b0, oupd[d]}, 5'b0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic [6:0] c, input logic [2:0] q,
                         input logic u, input logic e);
        if (d == 0) c4 = c;
        else c1 = c;
        sb.push_back('{ncyc + (d == 0 ? 4 : 1) + 3, d, {q, u, e}});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick(1);
            n++;
        end
        chk({tag, "_drain"}, 5'(sb.size()), 5'd0);
        tick(2);
    endtask

    initial begin
        tick(3);
        chk("reset_n4", {oq[0], oupd[0], oerr[0]}, 5'b0);
        chk("reset_n1", {oq[1], oupd[1], oerr[1]}, 5'b0);
        rst = 1'b0;
        tick(3);
        drive(0, 7'b0000111, 3'd3, 1'b1, 1'b0);
        wait_idle("lvl3");
        c4 = 7'b0011111;
        tick(2);
        drive(0, 7'b0000111, 3'd3, 1'b0, 1'b0);
        wait_idle("bounce");
        drive(0, 7'b0000101, 3'd3, 1'b0, 1'b1);
        wait_idle("illegal");
        drive(0, 7'b0000001, 3'd1, 1'b1, 1'b0);
        wait_idle("lvl1");
        drive(0, 7'b1111111, 3'd1, 1'b0, 1'b1);
        wait_idle("all_on");
        drive(0, 7'b0111111, 3'd6, 1'b1, 1'b0);
        wait_idle("lvl6");
        c4 = 7'b0000000;
        tick(4);
        drive(0, 7'b0111111, 3'd6, 1'b0, 1'b0);
        wait_idle("glitch4");
        drive(0, 7'b0000000, 3'd0, 1'b1, 1'b0);
        tick(5);
        drive(0, 7'b0111111, 3'd6, 1'b1, 1'b0);
        wait_idle("hold5");
        c4 = 7'b0001111;
        tick(5);
        rst = 1'b1;
        #1;
        chk("midsettle_rst_n4", {oq[0], oupd[0], oerr[0]}, 5'b0);
        chk("midsettle_rst_n1", {oq[1], oupd[1], oerr[1]}, 5'b0);
        tick(2);
        rst = 1'b0;
        sb.push_back('{ncyc + 7, 0, {3'd4, 1'b1, 1'b0}});
        wait_idle("post_rst");
        drive(1, 7'b0000011, 3'd2, 1'b1, 1'b0);
        wait_idle("n1_lvl2");
        c1 = 7'b0000000;
        tick(1);
        drive(1, 7'b0000011, 3'd2, 1'b0, 1'b0);
        wait_idle("n1_glitch1");
        drive(1, 7'b0000001, 3'd1, 1'b1, 1'b0);
        tick(2);
        drive(1, 7'b0000011, 3'd2, 1'b1, 1'b0);
        wait_idle("n1_glitch2");
        drive(1, 7'b0101010, 3'd2, 1'b0, 1'b1);
        wait_idle("n1_illegal");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
